dmem_dump_ctrl: RTL and testbench

- Sequencer and arbiter for the data memory in the MEM stage.
- Normally passes the pipeline's read/write request straight to data memory.
- On a debug dump request it stalls the pipeline, takes the memory port, and sweeps word addresses 0..DEPTH-1.
- Each read word is serialised MSB-byte-first onto a valid/ready byte stream toward the debug UART transmitter.

---
 rtl/dmem_dump_ctrl_pkg.sv | 36 +++
 rtl/dmem_dump_ctrl_if.sv | 33 +++
 rtl/dmem_dump_ctrl_word_serializer.sv | 55 +++++
 rtl/dmem_dump_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_dump_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_dump_ctrl_pkg.sv
// Shared types and constants for the data-memory debug dump path.
// Holds the dump FSM state encoding, memory read_write codes and byte width.
// Also provides the helper that picks one byte of a word, MSB first.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    ADDR  = 3'd2,
    WAIT  = 3'd3,
    SEND  = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } dump_state_e;

  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_NONE  = 2'b00;

  localparam int DBG_BYTE_W = 8;
  localparam int WORD_W     = 32;

  // Byte 0 is the most significant byte of the word.
  function automatic logic [DBG_BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w,
                                                     input logic [1:0] bc);
    logic [DBG_BYTE_W-1:0] b;
    case (bc)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dmem_dump_ctrl_if.sv
// Bundle of pipeline, data-memory and debug byte-stream signals of the dump controller.
// master = the dump controller, slave = pipeline/memory/transmitter side.
// The byte stream is valid/ready; everything else is level signalling.
interface dmem_dump_ctrl_if;
  import mips_dbg_pkg::*;

  logic                  dump_start;
  logic                  dump_busy;
  logic                  dump_done;
  logic                  pipe_stall;
  logic                  pipe_idle;
  logic [1:0]            pipe_rw;
  logic [31:0]           pipe_addr;
  logic                  mem_debug_on;
  logic [1:0]            mem_rw;
  logic [31:0]           mem_dbg_addr;
  logic [WORD_W-1:0]     mem_rdata;
  logic [DBG_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    input  dump_start, pipe_idle, pipe_rw, pipe_addr, mem_rdata, tx_ready,
    output dump_busy, dump_done, pipe_stall, mem_debug_on, mem_rw, mem_dbg_addr,
           tx_data, tx_valid
  );

  modport slave (
    output dump_start, pipe_idle, pipe_rw, pipe_addr, mem_rdata, tx_ready,
    input  dump_busy, dump_done, pipe_stall, mem_debug_on, mem_rw, mem_dbg_addr,
           tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_dump_ctrl_word_serializer.sv
// Serialises one 32-bit word into four bytes, MSB first, on a valid/ready stream.
// Latency: first byte valid the cycle after load_i; one byte per accepted handshake.
// Backpressure: data_o/valid_o hold while ready_i is low; last_o marks acceptance of byte 3.
module word_serializer
  import mips_dbg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [WORD_W-1:0]     word_i,
  input  logic                  ready_i,
  output logic [DBG_BYTE_W-1:0] data_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  last_o
);

  logic [WORD_W-1:0]     word_q;
  logic [1:0]            bc_q;
  logic                  valid_q;
  logic [DBG_BYTE_W-1:0] data_q;
  logic                  accept;

  assign accept = valid_q && ready_i;

  // Load a word, then step through its bytes on each accepted handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      bc_q    <= 2'd0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      word_q  <= word_i;
      bc_q    <= 2'd0;
      valid_q <= 1'b1;
      data_q  <= byte_of(word_i, 2'd0);
    end else if (accept) begin
      if (bc_q == 2'd3) begin
        // Keep the last byte on data_o; only valid drops.
        bc_q    <= 2'd0;
        valid_q <= 1'b0;
      end else begin
        bc_q   <= bc_q + 2'd1;
        data_q <= byte_of(word_q, bc_q + 2'd1);
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = valid_q;
  assign last_o  = accept && (bc_q == 2'd3);

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Data-memory arbiter: passes pipeline accesses through, or stalls the pipeline and dumps words 0..DEPTH-1.
// Latency: 1 + MEM_LAT + 4 + 1 cycles per word with the transmitter always ready.
// Backpressure: waits indefinitely on tx_ready; the pipeline stays stalled for the whole dump.
module dmem_dump_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int MEM_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_dump_ctrl_if.master bus
);

  localparam logic [1:0]    LAT_LOAD = 2'(MEM_LAT - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  dump_state_e   state_q;
  logic [AW-1:0] index_q;
  logic [AW-1:0] addr_q;
  logic [1:0]    lat_q;
  logic          busy_q;
  logic          done_q;
  logic          stall_q;
  logic          dbg_on_q;

  logic                  ser_load;
  logic                  ser_busy;
  logic                  ser_last;
  logic [DBG_BYTE_W-1:0] ser_data;
  logic                  ser_valid;

  // Capture the read word once the memory latency has elapsed; never overwrite a word still going out.
  assign ser_load = (state_q == WAIT) && (lat_q == 2'd0) && !ser_busy;

  // Dump sequencer. The address register is updated on entry to ADDR so the
  // memory sees a stable address for the whole ADDR+WAIT window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      addr_q   <= '0;
      lat_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stall_q  <= 1'b0;
      dbg_on_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.dump_start) begin
            state_q <= DRAIN;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          // Memory ownership only after the stalled pipeline reports no access in flight.
          if (bus.pipe_idle) begin
            state_q  <= ADDR;
            dbg_on_q <= 1'b1;
            addr_q   <= index_q;
          end
        end
        ADDR: begin
          addr_q  <= index_q;
          lat_q   <= LAT_LOAD;
          state_q <= WAIT;
        end
        WAIT: begin
          if (lat_q == 2'd0) state_q <= SEND;
          else               lat_q   <= lat_q - 2'd1;
        end
        SEND: begin
          if (ser_last) state_q <= NEXT;
        end
        NEXT: begin
          if (index_q == LAST_IDX) begin
            index_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            index_q <= index_q + 1'b1;
            addr_q  <= index_q + 1'b1;
            state_q <= ADDR;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          dbg_on_q <= 1'b0;
          stall_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  word_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .word_i  (bus.mem_rdata),
    .ready_i (bus.tx_ready),
    .data_o  (ser_data),
    .valid_o (ser_valid),
    .busy_o  (ser_busy),
    .last_o  (ser_last)
  );

  assign bus.dump_busy    = busy_q;
  assign bus.dump_done    = done_q;
  assign bus.pipe_stall   = stall_q;
  assign bus.mem_debug_on = dbg_on_q;
  assign bus.mem_rw       = dbg_on_q ? RW_READ : bus.pipe_rw;
  assign bus.mem_dbg_addr = {{(32-AW){1'b0}}, addr_q};
  assign bus.tx_data      = ser_data;
  assign bus.tx_valid     = ser_valid;

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Directed bench for dmem_dump_ctrl: a MEM_LAT=1/DEPTH=32 instance and a MEM_LAT=3/DEPTH=6 instance.
// Memories are modelled as address delay lines of MEM_LAT stages.
// Accepted bytes are collected by monitors and compared against the preloaded contents.
module tb_dmem_dump_ctrl;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  dmem_dump_ctrl_if b1 ();
  dmem_dump_ctrl_if b3 ();

  dmem_dump_ctrl #(.DEPTH(32), .AW(5), .MEM_LAT(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1.master));
  dmem_dump_ctrl #(.DEPTH(6),  .AW(3), .MEM_LAT(3)) dut3 (.clk(clk), .rst(rst3), .bus(b3.master));

  function automatic logic [31:0] w1(int k);
    case (k)
      0:       return 32'hDEADBEEF;
      1:       return 32'h01234567;
      default: return {8'(k), ~8'(k), 8'h5A, 8'(k) ^ 8'hC3};
    endcase
  endfunction

  function automatic logic [31:0] w3(int k);
    return {8'hC0 + 8'(k), 8'(k * 3), 8'hE7, ~8'(k)};
  endfunction

  function automatic logic [7:0] eb(logic [31:0] w, int b);
    logic [31:0] s;
    s = w >> (8 * (3 - b));
    return s[7:0];
  endfunction

  // Memory models
  logic [31:0] mem1 [0:31];
  logic [31:0] mem3 [0:5];
  logic [4:0]  a1_q;
  logic [2:0]  a3_q [0:2];

  always @(posedge clk) begin
    a1_q    <= b1.mem_dbg_addr[4:0];
    a3_q[0] <= b3.mem_dbg_addr[2:0];
    a3_q[1] <= a3_q[0];
    a3_q[2] <= a3_q[1];
  end
  assign b1.mem_rdata = mem1[a1_q];
  assign b3.mem_rdata = (a3_q[2] < 3'd6) ? mem3[a3_q[2]] : 32'hBAD0BAD0;

  // Monitors
  int cyc = 0;
  logic [7:0] q1[$];
  logic [7:0] q3[$];
  int t1[$];
  int t3[$];
  int done1 = 0;
  int done3 = 0;
  int own_err1 = 0;
  int own_err3 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b1.tx_valid && b1.tx_ready) begin q1.push_back(b1.tx_data); t1.push_back(cyc); end
    if (b3.tx_valid && b3.tx_ready) begin q3.push_back(b3.tx_data); t3.push_back(cyc); end
    if (b1.dump_done) done1 <= done1 + 1;
    if (b3.dump_done) done3 <= done3 + 1;
    if ((b1.mem_debug_on || b1.tx_valid) && !b1.pipe_stall) own_err1 <= own_err1 + 1;
    if ((b3.mem_debug_on || b3.tx_valid) && !b3.pipe_stall) own_err3 <= own_err3 + 1;
  end

  task automatic wait_done1(input int limit, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (b1.dump_done) begin seen = 1'b1; break; end
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL %s_timeout: dump_done got 0 want 1 within %0d cycles", tag, limit); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    b1.dump_start = 1'b1; b3.dump_start = 1'b1;
    b1.pipe_idle = 1'b1; b3.pipe_idle = 1'b1;
    b1.pipe_rw = 2'b00; b3.pipe_rw = 2'b00;
    b1.pipe_addr = 32'h0; b3.pipe_addr = 32'h0;
    b1.tx_ready = 1'b0; b3.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (b1.dump_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", b1.dump_busy); end
    n_cmp++; if (b1.pipe_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", b1.pipe_stall); end
    n_cmp++; if (b1.mem_debug_on !== 1'b0) begin n_err++; $display("FAIL reset_dbg: got %b want 0", b1.mem_debug_on); end
    n_cmp++; if (b1.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", b1.tx_valid); end
    n_cmp++; if (b1.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", b1.tx_data); end
    n_cmp++; if (b1.mem_dbg_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", b1.mem_dbg_addr); end
    n_cmp++; if (b1.dump_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", b1.dump_done); end
    n_cmp++; if (b3.dump_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy3: got %b want 0", b3.dump_busy); end
    rst1 = 1'b0; rst3 = 1'b0;
    b1.dump_start = 1'b0; b3.dump_start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (b1.dump_busy !== 1'b0) begin n_err++; $display("FAIL reset_wins: busy got %b want 0", b1.dump_busy); end
  endtask

  task automatic test_passthrough();
    b1.pipe_rw = 2'b01; b1.pipe_addr = 32'd8;
    #1;
    n_cmp++; if (b1.mem_rw !== 2'b01) begin n_err++; $display("FAIL pass_rw_wr: got %b want 01", b1.mem_rw); end
    n_cmp++; if (b1.mem_debug_on !== 1'b0) begin n_err++; $display("FAIL pass_dbg: got %b want 0", b1.mem_debug_on); end
    n_cmp++; if (b1.pipe_stall !== 1'b0) begin n_err++; $display("FAIL pass_stall: got %b want 0", b1.pipe_stall); end
    b1.pipe_rw = 2'b10;
    #1;
    n_cmp++; if (b1.mem_rw !== 2'b10) begin n_err++; $display("FAIL pass_rw_rd: got %b want 10", b1.mem_rw); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_dump();
    logic rw_bad;
    int d0;
    rw_bad = 1'b0;
    q1.delete(); t1.delete();
    d0 = done1;
    b1.tx_ready = 1'b1; b1.pipe_idle = 1'b1; b1.pipe_rw = 2'b01;
    b1.dump_start = 1'b1;
    @(posedge clk); #1;
    b1.dump_start = 1'b0;
    n_cmp++; if (b1.dump_busy !== 1'b1) begin n_err++; $display("FAIL dump_busy_rise: got %b want 1", b1.dump_busy); end
    n_cmp++; if (b1.pipe_stall !== 1'b1) begin n_err++; $display("FAIL dump_stall_rise: got %b want 1", b1.pipe_stall); end
    n_cmp++; if (b1.mem_debug_on !== 1'b0) begin n_err++; $display("FAIL dump_dbg_drain: got %b want 0", b1.mem_debug_on); end
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (b1.mem_debug_on && b1.mem_rw !== 2'b10) rw_bad = 1'b1;
      if (b1.dump_done) break;
    end
    @(posedge clk); #1;
    n_cmp++; if (rw_bad !== 1'b0) begin n_err++; $display("FAIL dump_rw_forced: bad got %b want 0", rw_bad); end
    n_cmp++; if (b1.dump_busy !== 1'b0) begin n_err++; $display("FAIL dump_busy_fall: got %b want 0", b1.dump_busy); end
    n_cmp++; if (b1.pipe_stall !== 1'b0) begin n_err++; $display("FAIL dump_stall_fall: got %b want 0", b1.pipe_stall); end
    n_cmp++; if (b1.mem_rw !== 2'b01) begin n_err++; $display("FAIL dump_rw_back: got %b want 01", b1.mem_rw); end
    n_cmp++; if (done1 - d0 !== 1) begin n_err++; $display("FAIL dump_done_count: got %0d want 1", done1 - d0); end
    n_cmp++; if (q1.size() !== 128) begin n_err++; $display("FAIL dump_len: got %0d want 128", q1.size()); end
    for (int i = 0; i < q1.size() && i < 128; i++) begin
      n_cmp++;
      if (q1[i] !== eb(w1(i / 4), i % 4)) begin
        n_err++; $display("FAIL dump_byte%0d: got %h want %h", i, q1[i], eb(w1(i / 4), i % 4));
      end
    end
    if (t1.size() > 4) begin
      n_cmp++; if (t1[4] - t1[0] !== 7) begin n_err++; $display("FAIL dump_period: got %0d want 7", t1[4] - t1[0]); end
    end
  endtask

  task automatic test_drain_wait();
    b1.pipe_idle = 1'b0; b1.pipe_rw = 2'b01; b1.tx_ready = 1'b1;
    b1.dump_start = 1'b1;
    @(posedge clk); #1;
    b1.dump_start = 1'b0;
    n_cmp++; if (b1.pipe_stall !== 1'b1) begin n_err++; $display("FAIL drain_stall: got %b want 1", b1.pipe_stall); end
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      n_cmp++; if (b1.mem_debug_on !== 1'b0) begin n_err++; $display("FAIL drain_dbg_c%0d: got %b want 0", k, b1.mem_debug_on); end
    end
    b1.pipe_idle = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (b1.mem_debug_on !== 1'b1) begin n_err++; $display("FAIL drain_dbg_rise: got %b want 1", b1.mem_debug_on); end
    n_cmp++; if (b1.mem_rw !== 2'b10) begin n_err++; $display("FAIL drain_rw_read: got %b want 10", b1.mem_rw); end
    wait_done1(400, "drain");
  endtask

  task automatic test_backpressure();
    logic seen;
    int nbad;
    q1.delete(); t1.delete();
    b1.tx_ready = 1'b0; b1.pipe_idle = 1'b1;
    b1.dump_start = 1'b1;
    @(posedge clk); #1;
    b1.dump_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (b1.tx_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL bp_first_valid: got 0 want 1"); end
    @(posedge clk); #1;
    n_cmp++; if (b1.tx_data !== 8'hDE || b1.tx_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold0: got %h/%b want DE/1", b1.tx_data, b1.tx_valid); end
    b1.tx_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (b1.tx_data !== 8'hAD) begin n_err++; $display("FAIL bp_step1: got %h want AD", b1.tx_data); end
    b1.tx_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (b1.tx_data !== 8'hAD || b1.tx_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold1_%0d: got %h/%b want AD/1", k, b1.tx_data, b1.tx_valid); end
    end
    b1.tx_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (b1.tx_data !== 8'hBE) begin n_err++; $display("FAIL bp_step2: got %h want BE", b1.tx_data); end
    wait_done1(400, "bp");
    n_cmp++; if (q1.size() !== 128) begin n_err++; $display("FAIL bp_len: got %0d want 128", q1.size()); end
    nbad = 0;
    for (int i = 0; i < q1.size() && i < 128; i++) if (q1[i] !== eb(w1(i / 4), i % 4)) nbad++;
    n_cmp++; if (nbad !== 0) begin n_err++; $display("FAIL bp_bytes: bad got %0d want 0", nbad); end
  endtask

  task automatic test_reset_mid_dump();
    logic reached;
    q1.delete(); t1.delete();
    b1.tx_ready = 1'b1; b1.pipe_idle = 1'b1; b1.pipe_rw = 2'b01;
    b1.dump_start = 1'b1;
    @(posedge clk); #1;
    b1.dump_start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (q1.size() >= 14) begin reached = 1'b1; break; end
    end
    n_cmp++; if (!reached) begin n_err++; $display("FAIL rst_mid_reach: got %0d bytes want 14", q1.size()); end
    n_cmp++; if (b1.tx_data !== eb(w1(3), 2)) begin n_err++; $display("FAIL rst_mid_byte: got %h want %h", b1.tx_data, eb(w1(3), 2)); end
    rst1 = 1'b1; b1.tx_ready = 1'b0;
    @(posedge clk); #1;
    rst1 = 1'b0;
    n_cmp++; if (b1.tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", b1.tx_valid); end
    n_cmp++; if (b1.pipe_stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall: got %b want 0", b1.pipe_stall); end
    n_cmp++; if (b1.mem_debug_on !== 1'b0) begin n_err++; $display("FAIL rst_mid_dbg: got %b want 0", b1.mem_debug_on); end
    n_cmp++; if (b1.mem_rw !== 2'b01) begin n_err++; $display("FAIL rst_mid_rw: got %b want 01", b1.mem_rw); end
    n_cmp++; if (b1.dump_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", b1.dump_busy); end
    q1.delete(); t1.delete();
    b1.tx_ready = 1'b1;
    b1.dump_start = 1'b1;
    @(posedge clk); #1;
    b1.dump_start = 1'b0;
    wait_done1(400, "restart");
    n_cmp++; if (q1.size() !== 128) begin n_err++; $display("FAIL restart_len: got %0d want 128", q1.size()); end
    for (int i = 0; i < 4 && i < q1.size(); i++) begin
      n_cmp++; if (q1[i] !== eb(32'hDEADBEEF, i)) begin n_err++; $display("FAIL restart_byte%0d: got %h want %h", i, q1[i], eb(32'hDEADBEEF, i)); end
    end
  endtask

  task automatic test_lat3();
    int lat;
    int d0;
    int nbad;
    logic seen;
    q3.delete(); t3.delete();
    d0 = done3;
    lat = -1;
    b3.tx_ready = 1'b1; b3.pipe_idle = 1'b1; b3.pipe_rw = 2'b00;
    b3.dump_start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) b3.dump_start = 1'b0;
      if (b3.tx_valid) begin lat = c; break; end
    end
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL lat3_first: got %0d want 6", lat); end
    @(posedge clk); #1;
    n_cmp++; if (b3.dump_busy !== 1'b1) begin n_err++; $display("FAIL lat3_busy: got %b want 1", b3.dump_busy); end
    b3.dump_start = 1'b1;
    @(posedge clk); #1;
    b3.dump_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (b3.dump_done) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL lat3_timeout: dump_done got 0 want 1"); end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (b3.dump_busy !== 1'b0) begin n_err++; $display("FAIL lat3_no_queue: busy got %b want 0", b3.dump_busy); end
    n_cmp++; if (done3 - d0 !== 1) begin n_err++; $display("FAIL lat3_done_count: got %0d want 1", done3 - d0); end
    n_cmp++; if (q3.size() !== 24) begin n_err++; $display("FAIL lat3_len: got %0d want 24", q3.size()); end
    nbad = 0;
    for (int i = 0; i < q3.size() && i < 24; i++) if (q3[i] !== eb(w3(i / 4), i % 4)) nbad++;
    n_cmp++; if (nbad !== 0) begin n_err++; $display("FAIL lat3_bytes: bad got %0d want 0", nbad); end
    if (t3.size() > 4) begin
      n_cmp++; if (t3[4] - t3[0] !== 9) begin n_err++; $display("FAIL lat3_period: got %0d want 9", t3[4] - t3[0]); end
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem1[k] = w1(k);
    for (int k = 0; k < 6; k++)  mem3[k] = w3(k);
    test_reset();
    test_passthrough();
    test_full_dump();
    test_drain_wait();
    test_backpressure();
    test_reset_mid_dump();
    test_lat3();
    n_cmp++; if (own_err1 !== 0) begin n_err++; $display("FAIL own1: unstalled ownership cycles got %0d want 0", own_err1); end
    n_cmp++; if (own_err3 !== 0) begin n_err++; $display("FAIL own3: unstalled ownership cycles got %0d want 0", own_err3); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
